sdr_bit_to_symbol_packer: RTL and testbench

- Upstream neighbour of the symbol mapper. Converts a byte-oriented payload stream into MSB-first symbol indices of the width set by the active modulation. The width is the symbol_size field of the modulation settings: 1..12 bits.
- Has valid/ready handshakes on both sides, frame-end padding, and a symbol-size change accepted only at frame boundaries.
- The output index drives the mapper's constellation lookup directly.

---
 rtl/sdr_bit_to_symbol_packer_pkg.sv | 25 ++
 rtl/sdr_bit_to_symbol_packer_if.sv | 29 ++
 rtl/sdr_bit_to_symbol_packer_shift_buffer.sv | 62 ++++++
 rtl/sdr_bit_to_symbol_packer.sv | 132 +++++++++++++
 tb/tb_sdr_bit_to_symbol_packer.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdr_bit_to_symbol_packer_pkg.sv
// Shared constants, types and helpers for the bit-to-symbol packer.
// Symbol sizes here are in bits per symbol.
package sdr_bit_to_symbol_packer_pkg;

  localparam int SDR_MAX_SYMBOL_SIZE = 12;

  typedef logic [SDR_MAX_SYMBOL_SIZE-1:0] t_sym_idx;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } t_pack_state;

  function automatic int clamp_symbol_size(input int size);
    if (size < 1) return 1;
    if (size > SDR_MAX_SYMBOL_SIZE) return SDR_MAX_SYMBOL_SIZE;
    return size;
  endfunction

  function automatic logic symbol_size_illegal(input int size);
    return (size < 1) || (size > SDR_MAX_SYMBOL_SIZE);
  endfunction

endpackage

// File: rtl/sdr_bit_to_symbol_packer_if.sv
// Payload-in / symbol-out handshake bundle of the bit-to-symbol packer.
// The master modport is the packer side; the slave modport is its environment.
interface sdr_bit_to_symbol_packer_if
  import sdr_bit_to_symbol_packer_pkg::*;
#(
  parameter int DW      = 8,
  parameter int MAX_SYM = SDR_MAX_SYMBOL_SIZE
);

  logic               i_valid;
  logic [DW-1:0]      i_data;
  logic               i_last;
  logic               o_ready;
  logic               o_valid;
  logic [MAX_SYM-1:0] o_data;
  logic               o_last;
  logic               i_ready;

  modport master (
    input  i_valid, i_data, i_last, i_ready,
    output o_ready, o_valid, o_data, o_last
  );

  modport slave (
    output i_valid, i_data, i_last, i_ready,
    input  o_ready, o_valid, o_data, o_last
  );

endinterface

// File: rtl/sdr_bit_to_symbol_packer_shift_buffer.sv
// Left-aligned bit buffer with a variable-size pop from the top and an append
// directly below the surviving bits. Bits below cnt are always kept at zero.
module sdr_bit_shift_buffer #(
  parameter int  DW      = 8,
  parameter int  MAX_SYM = 12,
  localparam int BW      = DW + MAX_SYM - 1,
  localparam int CW      = $clog2(BW + 1),
  localparam int SW      = $clog2(MAX_SYM + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [DW-1:0]      push_data,
  input  logic               pop,
  input  logic [SW-1:0]      pop_size,
  input  logic [SW-1:0]      head_size,
  output logic [CW-1:0]      cnt_next,
  output logic [MAX_SYM-1:0] head_next
);

  logic [BW-1:0] bits;
  logic [BW-1:0] bits_next;
  logic [BW-1:0] bits_rem;
  logic [BW-1:0] word_al;
  logic [BW-1:0] head_al;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_rem;
  logic [CW-1:0] pop_ext;

  always_comb begin
    pop_ext  = CW'(pop_size);
    bits_rem = bits;
    cnt_rem  = cnt;
    // A pop larger than the fill only happens for the padded final symbol.
    if (pop) begin
      bits_rem = bits << pop_size;
      cnt_rem  = (cnt > pop_ext) ? cnt - pop_ext : '0;
    end

    word_al   = {push_data, {(BW-DW){1'b0}}};
    bits_next = bits_rem;
    cnt_next  = cnt_rem;
    if (push) begin
      bits_next = bits_rem | (word_al >> cnt_rem);
      cnt_next  = cnt_rem + CW'(DW);
    end

    head_al   = bits_next >> (CW'(BW) - CW'(head_size));
    head_next = head_al[MAX_SYM-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits <= '0;
      cnt  <= '0;
    end else begin
      bits <= bits_next;
      cnt  <= cnt_next;
    end
  end

endmodule

// File: rtl/sdr_bit_to_symbol_packer.sv
// Packs an MSB-first payload word stream into right-aligned symbol indices of
// the frame's latched symbol size, with zero padding of the final symbol.
module sdr_bit_to_symbol_packer
  import sdr_bit_to_symbol_packer_pkg::*;
#(
  parameter int DW      = 8,
  parameter int MAX_SYM = SDR_MAX_SYMBOL_SIZE
) (
  input  logic                       iclk,
  input  logic                       irst_n,
  input  logic [3:0]                 isymbol_size,
  sdr_bit_to_symbol_packer_if.master bus,
  output logic                       o_cfg_err
);

  localparam int BW = DW + MAX_SYM - 1;
  localparam int CW = $clog2(BW + 1);
  localparam int SW = $clog2(MAX_SYM + 1);

  t_pack_state        state;
  t_pack_state        state_next;
  logic [SW-1:0]      sym;
  logic [SW-1:0]      sym_next;
  logic [SW-1:0]      sym_in;
  logic [CW-1:0]      sym_ext;
  logic               err_next;
  logic               push;
  logic               pop;
  logic               valid_q;
  logic               last_q;
  logic               ready_q;
  logic [MAX_SYM-1:0] data_q;
  logic               valid_next;
  logic               last_next;
  logic               ready_next;
  logic [CW-1:0]      cnt_next;
  logic [CW:0]        fill_after_push;
  logic [MAX_SYM-1:0] head_next;

  assign push   = bus.i_valid && ready_q;
  assign pop    = valid_q && bus.i_ready;
  assign sym_in = SW'(clamp_symbol_size(int'(isymbol_size)));

  sdr_bit_shift_buffer #(
    .DW      (DW),
    .MAX_SYM (MAX_SYM)
  ) u_buf (
    .clk       (iclk),
    .rst_n     (irst_n),
    .push      (push),
    .push_data (bus.i_data),
    .pop       (pop),
    .pop_size  (sym),
    .head_size (sym_next),
    .cnt_next  (cnt_next),
    .head_next (head_next)
  );

  always_comb begin
    state_next = state;
    sym_next   = sym;
    err_next   = o_cfg_err;
    unique case (state)
      ST_IDLE: begin
        // The symbol size is sampled only with the first word of a frame.
        if (push) begin
          sym_next   = sym_in;
          err_next   = o_cfg_err | symbol_size_illegal(int'(isymbol_size));
          state_next = bus.i_last ? ST_FLUSH : ST_RUN;
        end
      end
      ST_RUN: begin
        if (push && bus.i_last) state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (pop && last_q) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Registered outputs are derived from the post-edge buffer contents.
  always_comb begin
    sym_ext         = CW'(sym_next);
    fill_after_push = {1'b0, cnt_next} + (CW+1)'(DW);
    valid_next      = 1'b0;
    last_next       = 1'b0;
    ready_next      = 1'b0;
    unique case (state_next)
      ST_IDLE: begin
        ready_next = 1'b1;
      end
      ST_RUN: begin
        valid_next = cnt_next >= sym_ext;
        ready_next = fill_after_push <= (CW+1)'(BW);
      end
      ST_FLUSH: begin
        valid_next = cnt_next != '0;
        last_next  = cnt_next <= sym_ext;
      end
      default: begin
        ready_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state     <= ST_IDLE;
      sym       <= SW'(1);
      o_cfg_err <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      ready_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      state     <= state_next;
      sym       <= sym_next;
      o_cfg_err <= err_next;
      valid_q   <= valid_next;
      last_q    <= last_next;
      ready_q   <= ready_next;
      data_q    <= head_next;
    end
  end

  assign bus.o_valid = valid_q;
  assign bus.o_last  = last_q;
  assign bus.o_ready = ready_q;
  assign bus.o_data  = data_q;

endmodule

// File: tb/tb_sdr_bit_to_symbol_packer.sv
// Directed bench for the bit-to-symbol packer: a bit-serialiser model builds the
// expected symbol stream of each frame and one process checks every transfer.
module tb_sdr_bit_to_symbol_packer;
  import sdr_bit_to_symbol_packer_pkg::*;

  localparam int DW = 8;
  localparam int BW = DW + SDR_MAX_SYMBOL_SIZE - 1;

  typedef struct packed {
    t_sym_idx d;
    logic     l;
  } exp_t;

  logic       iclk = 1'b0;
  logic       irst_n = 1'b0;
  logic [3:0] isymbol_size = 4'd2;
  logic       o_cfg_err;

  sdr_bit_to_symbol_packer_if #(.DW(DW), .MAX_SYM(SDR_MAX_SYMBOL_SIZE)) bus ();

  sdr_bit_to_symbol_packer #(.DW(DW), .MAX_SYM(SDR_MAX_SYMBOL_SIZE)) dut (
    .iclk         (iclk),
    .irst_n       (irst_n),
    .isymbol_size (isymbol_size),
    .bus          (bus),
    .o_cfg_err    (o_cfg_err)
  );

  always #5 iclk = ~iclk;

  int         n_cmp = 0;
  int         n_bad = 0;
  exp_t       exp_q[$];
  int         built_q[$];
  int         lit_q[$];
  logic [7:0] frame_q[$];
  int         rdy_mode = 0;
  int         cur_s = 1;
  int         inflight = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic int bench_size(input int size);
    if (size < 1) return 1;
    if (size > 12) return 12;
    return size;
  endfunction

  // Reference serialiser: flatten the frame MSB-first and cut it into symbols.
  task automatic build_exp(input int size);
    int   s;
    int   nb;
    int   v;
    logic bits[$];
    s = bench_size(size);
    built_q.delete();
    foreach (frame_q[w])
      for (int b = DW - 1; b >= 0; b--) bits.push_back(frame_q[w][b]);
    nb = bits.size();
    for (int i = 0; i < nb; i += s) begin
      v = 0;
      for (int j = 0; j < s; j++) v = (v << 1) | ((i + j < nb) ? int'(bits[i+j]) : 0);
      built_q.push_back(v);
      exp_q.push_back('{d: t_sym_idx'(v), l: (i + s >= nb)});
    end
  endtask

  task automatic pin(input string name);
    check({name, " symbol count"}, built_q.size(), lit_q.size());
    for (int i = 0; i < lit_q.size() && i < built_q.size(); i++)
      check({name, " model symbol"}, built_q[i], lit_q[i]);
  endtask

  task automatic push_word(input logic [7:0] d, input logic l);
    int k2;
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    bus.i_last  = l;
    k2 = 0;
    while (k2 < 200) begin
      @(negedge iclk);
      if (bus.o_ready) break;
      k2++;
    end
    check("input accepted in time", k2 < 200, 1);
    if (k2 < 200) @(posedge iclk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
  endtask

  task automatic run_frame(input int size, input int size_after);
    int n;
    int k2;
    n = frame_q.size();
    cur_s = bench_size(size);
    build_exp(size);
    isymbol_size = 4'(size);
    for (int k = 0; k < n; k++) begin
      push_word(frame_q[k], k == n - 1);
      if (k == 0 && size_after >= 0) isymbol_size = 4'(size_after);
      if (k == 0 || k == n - 1) begin
        @(negedge iclk);
        if (k == 0) check("first symbol latency", bus.o_valid, cur_s <= DW);
        if (k == n - 1) check("o_ready low in flush", bus.o_ready, 0);
        @(posedge iclk);
        #1;
      end
    end
    k2 = 0;
    while (exp_q.size() != 0 && k2 < 2000) begin
      @(negedge iclk);
      k2++;
    end
    check("frame drained", exp_q.size(), 0);
    exp_q.delete();
    @(posedge iclk);
    @(negedge iclk);
    check("o_ready after frame", bus.o_ready, 1);
    check("o_valid idle after frame", bus.o_valid, 0);
    @(posedge iclk);
    #1;
  endtask

  initial begin
    bus.i_ready = 1'b1;
    forever begin
      @(posedge iclk);
      #1;
      case (rdy_mode)
        0:       bus.i_ready = 1'b1;
        1:       bus.i_ready = ~bus.i_ready;
        2:       bus.i_ready = 1'($urandom_range(0, 1));
        default: bus.i_ready = 1'b0;
      endcase
    end
  end

  // Per-cycle compare against the model queue, stall stability and fill bound.
  initial begin
    logic     prev_stall;
    t_sym_idx prev_d;
    logic     prev_l;
    exp_t     e;
    prev_stall = 1'b0;
    prev_d     = '0;
    prev_l     = 1'b0;
    forever begin
      @(negedge iclk);
      if (!irst_n) begin
        prev_stall = 1'b0;
        inflight   = 0;
      end else begin
        if (prev_stall) begin
          check("stall o_valid held", bus.o_valid, 1);
          check("stall o_data held", bus.o_data, prev_d);
          check("stall o_last held", bus.o_last, prev_l);
        end
        if (bus.o_ready) check("no buffer overflow", inflight + DW <= BW, 1);
        if (bus.o_valid && bus.i_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected symbol: got 0x%0h last=%0b, expected none at %0t",
                     bus.o_data, bus.o_last, $time);
          end else begin
            e = exp_q.pop_front();
            check("symbol data", bus.o_data, e.d);
            check("symbol last", bus.o_last, e.l);
          end
          inflight = (inflight > cur_s) ? inflight - cur_s : 0;
        end
        if (bus.i_valid && bus.o_ready) inflight += DW;
        prev_stall = bus.o_valid && !bus.i_ready;
        prev_d     = bus.o_data;
        prev_l     = bus.o_last;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_last  = 1'b0;
    #12;
    check("reset o_valid", bus.o_valid, 0);
    check("reset o_last", bus.o_last, 0);
    check("reset o_data", bus.o_data, 0);
    check("reset o_cfg_err", o_cfg_err, 0);
    check("reset o_ready", bus.o_ready, 0);
    @(negedge iclk);
    irst_n = 1'b1;
    @(posedge iclk);
    #1;
    check("o_ready after reset release", bus.o_ready, 1);

    frame_q = {8'hB4};
    run_frame(2, -1);
    lit_q = {2, 3, 1, 0};
    pin("qpsk");

    frame_q = {8'hFF, 8'h00};
    run_frame(3, -1);
    lit_q = {7, 7, 6, 0, 0, 0};
    pin("psk8");

    frame_q = {8'hAB, 8'hCD, 8'hEF};
    run_frame(12, -1);
    lit_q = {'hABC, 'hDEF};
    pin("qam4096");
    check("cfg_err clear for legal sizes", o_cfg_err, 0);

    rdy_mode = 1;
    frame_q = {8'hC3, 8'h5A};
    run_frame(1, -1);
    rdy_mode = 0;

    frame_q = {8'h1E, 8'h77};
    run_frame(2, 4);
    lit_q = {0, 1, 3, 2, 1, 3, 1, 3};
    pin("size change frame");
    frame_q = {8'h3C};
    run_frame(4, -1);
    lit_q = {3, 12};
    pin("next frame size 4");

    rdy_mode = 2;
    frame_q = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_frame(5, -1);
    rdy_mode = 0;

    frame_q = {8'hA5};
    run_frame(0, -1);
    lit_q = {1, 0, 1, 0, 0, 1, 0, 1};
    pin("size 0 as 1");
    check("cfg_err after size 0", o_cfg_err, 1);

    rdy_mode = 3;
    repeat (2) @(posedge iclk);
    #1;
    cur_s = 2;
    isymbol_size = 4'd2;
    push_word(8'h96, 1'b0);
    repeat (2) @(negedge iclk);
    check("stalled symbol before reset", bus.o_valid, 1);
    check("cfg_err sticky", o_cfg_err, 1);
    #2;
    irst_n = 1'b0;
    #1;
    check("mid-frame reset o_valid", bus.o_valid, 0);
    check("mid-frame reset o_last", bus.o_last, 0);
    check("mid-frame reset o_data", bus.o_data, 0);
    check("mid-frame reset o_cfg_err", o_cfg_err, 0);
    check("mid-frame reset o_ready", bus.o_ready, 0);
    @(negedge iclk);
    irst_n = 1'b1;
    rdy_mode = 0;
    repeat (6) @(negedge iclk);
    check("no symbol after reset", bus.o_valid, 0);
    @(posedge iclk);
    #1;

    frame_q = {8'hAB, 8'hCD, 8'hEF};
    run_frame(15, -1);
    lit_q = {'hABC, 'hDEF};
    pin("size 15 as 12");
    check("cfg_err after size 15", o_cfg_err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
